pwm_multi_channel: RTL

- Parametrised multi-channel PWM generator. Second-generation replacement for the single-channel PWM in the actuator output path.
- Takes CH signed fixed-point Q(N,F) duty words from the control datapath and saturates each into a RES-bit duty value.
- Duty values are double-buffered and update only at period boundaries, so no mid-period glitches.
- Supports edge-aligned or center-aligned counting and a clock prescaler; drives CH PWM pins from one shared counter.

---
 rtl/pwm_multi_channel_pkg.sv | 11 +
 rtl/pwm_multi_channel_if.sv | 30 +++
 rtl/pwm_multi_channel_duty_sat.sv | 30 +++
 rtl/pwm_multi_channel.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pwm_multi_channel_pkg.sv
// Shared constants for the multi-channel PWM generator.
// Counting-mode and counter-direction encodings.
package pwm_multi_channel_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control/duty inputs and PWM pin outputs of the PWM block.
// master drives duties and control, slave is the generator.
interface pwm_multi_channel_if #(
  parameter int CH = 4,
  parameter int N  = 24
);

  logic            enable;
  logic            mode;
  logic [CH*N-1:0] entrada;
  logic [CH-1:0]   salida;
  logic            period_start;

  modport master (
    output enable,
    output mode,
    output entrada,
    input  salida,
    input  period_start
  );

  modport slave (
    input  enable,
    input  mode,
    input  entrada,
    output salida,
    output period_start
  );

endinterface

// File: rtl/pwm_multi_channel_duty_sat.sv
// Saturates one signed Q(N,F) word into a RES-bit duty value.
// Negative -> 0, at or above full scale 2^IB -> all ones.
module pwm_duty_sat #(
  parameter int N   = 24,
  parameter int F   = 12,
  parameter int IB  = 5,
  parameter int RES = 16
) (
  input  logic [N-1:0]   word_i,
  output logic [RES-1:0] duty_o
);

  localparam int LSB = F + IB - RES;

  logic ovf;
  logic unused_lsb;

  assign ovf        = |word_i[N-2:F+IB];
  assign unused_lsb = ^word_i;

  always_comb begin
    duty_o = word_i[F+IB-1:LSB];
    if (word_i[N-1]) begin
      duty_o = '0;
    end else if (ovf) begin
      duty_o = '1;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// CH-channel PWM sharing one edge/center counter with prescaler.
// Duties are shadowed and reloaded only at period boundaries.
module pwm_multi_channel
  import pwm_multi_channel_pkg::*;
#(
  parameter int CH  = 4,
  parameter int N   = 24,
  parameter int F   = 12,
  parameter int IB  = 5,
  parameter int RES = 16,
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  pwm_multi_channel_if.slave pwm
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [RES-1:0] MAX = '1;
  localparam logic [RES-1:0] ONE = RES'(1);
  localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);

  logic [PW-1:0]  pre_q, pre_d;
  logic [RES-1:0] cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           mode_q, mode_d;
  logic           en_q;
  logic [CH-1:0]  sal_q, sal_d;
  logic           ps_q, ps_d;
  logic [RES-1:0] sat   [CH];
  logic [RES-1:0] shd_q [CH];
  logic [RES-1:0] shd_d [CH];
  logic           tick;
  logic           wrap;

  for (genvar g = 0; g < CH; g++) begin : g_sat
    pwm_duty_sat #(
      .N  (N),
      .F  (F),
      .IB (IB),
      .RES(RES)
    ) u_sat (
      .word_i(pwm.entrada[g*N +: N]),
      .duty_o(sat[g])
    );
  end

  assign tick = (pre_q == PRE_TOP);
  assign wrap = (mode_q == PWM_CENTER)
              ? (cnt_q == ONE && dir_q == DIR_DN)
              : (cnt_q == MAX);

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    sal_d  = sal_q;
    shd_d  = shd_q;
    ps_d   = 1'b0;
    if (!pwm.enable) begin
      pre_d  = '0;
      cnt_d  = '0;
      dir_d  = DIR_UP;
      sal_d  = '0;
      shd_d  = sat;
      mode_d = pwm.mode;
    end else if (!en_q) begin
      // first enabled clk: hold at 0 so the period starts cleanly
      ps_d = 1'b1;
    end else begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        for (int i = 0; i < CH; i++) begin
          sal_d[i] = (cnt_q < shd_q[i]);
        end
        if (wrap) begin
          cnt_d  = '0;
          dir_d  = DIR_UP;
          shd_d  = sat;
          mode_d = pwm.mode;
          ps_d   = 1'b1;
        end else if (mode_q == PWM_EDGE) begin
          cnt_d = cnt_q + ONE;
        end else if (dir_q == DIR_UP) begin
          if (cnt_q == MAX) begin
            dir_d = DIR_DN;
            cnt_d = MAX - ONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= PWM_EDGE;
      en_q   <= 1'b0;
      sal_q  <= '0;
      ps_q   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        shd_q[i] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      en_q   <= pwm.enable;
      sal_q  <= sal_d;
      ps_q   <= ps_d;
      shd_q  <= shd_d;
    end
  end

  assign pwm.salida       = sal_q;
  assign pwm.period_start = ps_q;

endmodule
